// File: rtl/dm_access_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage (port 0) and a DMA/loader (port 1).
// Optional round-robin tie-break in IDLE is enabled by defining DM_ARB_RR_EN.
module dm_access_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned BURST_MAX  = 8
) (
    input  logic        clk,
    input  logic        reset,
    // CPU (MEM stage) side
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    input  logic [1:0]  cpu_width,
    input  logic        cpu_sign,
    input  logic [31:0] cpu_pc,
    output logic        cpu_stall,
    output logic        cpu_gnt,
    // DMA / loader side
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wd,
    input  logic [1:0]  dma_width,
    input  logic        dma_sign,
    output logic        dma_gnt,
    // Data memory side
    input  logic [31:0] dm_rd,
    output logic [31:0] rdata,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [1:0]  dm_width,
    output logic        dm_sign,
    output logic [31:0] dm_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FORCE = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned BW = $clog2(BURST_MAX + 1);

    state_t        state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic          cpu_win, dma_win;
`ifdef DM_ARB_RR_EN
    logic          rr_last_q, rr_last_d;
`endif

    // burst_cnt counts locked DMA grants including the one that opened the burst,
    // so a burst never exceeds BURST_MAX grants in total.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        cpu_win      = 1'b0;
        dma_win      = 1'b0;
`ifdef DM_ARB_RR_EN
        rr_last_d    = rr_last_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef DM_ARB_RR_EN
                cpu_win = cpu_req & ~(dma_req & rr_last_q);
`else
                cpu_win = cpu_req;
`endif
                dma_win     = dma_req & ~cpu_win;
                burst_cnt_d = '0;
                if (dma_req & ~dma_win) begin
                    if (starve_cnt_q >= SW'(STARVE_MAX - 1)) begin
                        starve_cnt_d = SW'(STARVE_MAX);
                        state_d      = FORCE;
                    end else begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else begin
                    starve_cnt_d = '0;
                    if (dma_win & dma_lock) begin
                        state_d     = BURST;
                        burst_cnt_d = BW'(1);
                    end
                end
            end
            FORCE: begin
                dma_win      = dma_req;
                starve_cnt_d = '0;
                if (dma_req & dma_lock) begin
                    state_d     = BURST;
                    burst_cnt_d = BW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                dma_win      = dma_req;
                starve_cnt_d = '0;
                if (~dma_req | ~dma_lock | (burst_cnt_q >= BW'(BURST_MAX - 1))) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                starve_cnt_d = '0;
                burst_cnt_d  = '0;
            end
        endcase
`ifdef DM_ARB_RR_EN
        // rr_last = 1 means the CPU took the most recent grant
        if (cpu_win) begin
            rr_last_d = 1'b1;
        end else if (dma_win) begin
            rr_last_d = 1'b0;
        end
`endif
        if (reset) begin
            cpu_win = 1'b0;
            dma_win = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
`ifdef DM_ARB_RR_EN
            rr_last_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
`ifdef DM_ARB_RR_EN
            rr_last_q    <= rr_last_d;
`endif
        end
    end

    always_comb begin
        cpu_gnt   = cpu_win;
        dma_gnt   = dma_win;
        cpu_stall = cpu_req & ~cpu_win & ~reset;
        dm_we     = (cpu_win & cpu_we) | (dma_win & dma_we);
        dm_addr   = dma_win ? dma_addr  : cpu_addr;
        dm_wd     = dma_win ? dma_wd    : cpu_wd;
        dm_width  = dma_win ? dma_width : cpu_width;
        dm_sign   = dma_win ? dma_sign  : cpu_sign;
        dm_pc     = cpu_win ? cpu_pc    : '0;
        rdata     = dm_rd;
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Self-checking bench for dm_access_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural arbitration model and a reference memory.
module tb_dm_access_arbiter;

    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned BURST_MAX  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_sign;
    logic [31:0] cpu_addr, cpu_wd, cpu_pc;
    logic [1:0]  cpu_width;
    logic        cpu_stall, cpu_gnt;
    logic        dma_req, dma_lock, dma_we, dma_sign;
    logic [31:0] dma_addr, dma_wd;
    logic [1:0]  dma_width;
    logic        dma_gnt;
    logic [31:0] dm_rd, rdata, dm_addr, dm_wd, dm_pc;
    logic        dm_we, dm_sign;
    logic [1:0]  dm_width;

    int errors = 0;
    int checks = 0;

    dm_access_arbiter #(.STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_width(cpu_width), .cpu_sign(cpu_sign), .cpu_pc(cpu_pc),
        .cpu_stall(cpu_stall), .cpu_gnt(cpu_gnt),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wd(dma_wd), .dma_width(dma_width), .dma_sign(dma_sign), .dma_gnt(dma_gnt),
        .dm_rd(dm_rd), .rdata(rdata), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .dm_width(dm_width), .dm_sign(dm_sign), .dm_pc(dm_pc)
    );

    always #5 clk = ~clk;

    // Little-endian byte-addressed memory behaviour shared by the DM and the reference.
    function automatic logic [31:0] ld_word(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] width, input logic sgn);
        logic [31:0] s;
        case (width)
            2'd1: begin
                s = w >> (off[1] ? 16 : 0);
                return sgn ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
            end
            2'd2: begin
                s = w >> (8 * int'(off));
                return sgn ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
            end
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_word(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] width, input logic [31:0] wd);
        logic [31:0] m;
        int          sh;
        case (width)
            2'd1:    begin sh = off[1] ? 16 : 0; m = 32'h0000FFFF << sh; end
            2'd2:    begin sh = 8 * int'(off);   m = 32'h000000FF << sh; end
            default: begin sh = 0;               m = 32'hFFFFFFFF;       end
        endcase
        return (w & ~m) | ((wd << sh) & m);
    endfunction

    // Data memory attached to the DUT's DM port
    logic [31:0] dm_mem [64] = '{default: 32'h0};
    always_comb dm_rd = ld_word(dm_mem[dm_addr[7:2]], dm_addr[1:0], dm_width, dm_sign);
    always @(posedge clk) begin
        if (dm_we) dm_mem[dm_addr[7:2]] <= st_word(dm_mem[dm_addr[7:2]], dm_addr[1:0], dm_width, dm_wd);
    end

    // Reference model: forced grant owed, locked grants still allowed, starvation run length
    logic [31:0] ref_mem [64] = '{default: 32'h0};
    bit          m_force      = 1'b0;
    int unsigned m_burst_left = 0;
    int unsigned m_starve     = 0;
`ifdef DM_ARB_RR_EN
    bit          m_cpu_last   = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic        e_cpu, e_dma, e_we;
        logic [31:0] a, wd, pc;
        logic [1:0]  w;
        logic        sg;
        e_cpu = 1'b0;
        e_dma = 1'b0;
        if (!reset) begin
            if (m_force || m_burst_left > 0) begin
                e_dma = dma_req;
            end else begin
`ifdef DM_ARB_RR_EN
                e_cpu = cpu_req && !(dma_req && m_cpu_last);
`else
                e_cpu = cpu_req;
`endif
                e_dma = dma_req && !e_cpu;
            end
        end
        e_we = (e_cpu && cpu_we) || (e_dma && dma_we);
        chk("cpu_gnt", cpu_gnt, e_cpu);
        chk("dma_gnt", dma_gnt, e_dma);
        chk("cpu_stall", cpu_stall, !reset && cpu_req && !e_cpu);
        chk("dm_we", dm_we, e_we);
        a = e_dma ? dma_addr : cpu_addr;
        wd = e_dma ? dma_wd : cpu_wd;
        w = e_dma ? dma_width : cpu_width;
        sg = e_dma ? dma_sign : cpu_sign;
        pc = e_cpu ? cpu_pc : 32'h0;
        if (e_cpu || e_dma) begin
            chk("dm_addr", dm_addr, a);
            chk("dm_wd", dm_wd, wd);
            chk("dm_width", dm_width, w);
            chk("dm_sign", dm_sign, sg);
            chk("dm_pc", dm_pc, pc);
            if (!e_we) chk("rdata", rdata, ld_word(ref_mem[a[7:2]], a[1:0], w, sg));
        end
        if (e_we) ref_mem[a[7:2]] = st_word(ref_mem[a[7:2]], a[1:0], w, wd);
        // advance abstract state to the next cycle
        if (reset) begin
            m_force = 1'b0; m_burst_left = 0; m_starve = 0;
`ifdef DM_ARB_RR_EN
            m_cpu_last = 1'b0;
`endif
        end else begin
            if (m_force) begin
                m_force = 1'b0;
                m_starve = 0;
                m_burst_left = (dma_req && dma_lock) ? BURST_MAX - 1 : 0;
            end else if (m_burst_left > 0) begin
                m_burst_left = (dma_req && dma_lock) ? m_burst_left - 1 : 0;
            end else if (dma_req && !e_dma) begin
                m_starve++;
                if (m_starve == STARVE_MAX) m_force = 1'b1;
            end else begin
                m_starve = 0;
                if (e_dma && dma_lock) m_burst_left = BURST_MAX - 1;
            end
`ifdef DM_ARB_RR_EN
            if (e_cpu) m_cpu_last = 1'b1;
            else if (e_dma) m_cpu_last = 1'b0;
`endif
        end
    endtask

    task automatic settle();
        #1;
        model_step();
    endtask

    task automatic advance();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0; cpu_width = 2'd0;
        cpu_sign = 1'b0; cpu_pc = '0;
        dma_req = 1'b0; dma_lock = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wd = '0;
        dma_width = 2'd0; dma_sign = 1'b0;
    endtask

    logic [11:0] pat_c, pat_d, pat_s;

    initial begin
        idle_inputs();
        @(negedge clk);

        // reset with both requesters active
        reset = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
        settle();
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_we", dm_we, 0);
        advance();

        // CPU store then load of the same word
        idle_inputs();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wd = 32'h12345678; cpu_pc = 32'h400;
        settle();
        chk("t1_gnt", cpu_gnt, 1);
        chk("t1_we", dm_we, 1);
        chk("t1_pc", dm_pc, 32'h400);
        chk("t1_stall", cpu_stall, 0);
        advance();
        cpu_we = 1'b0; cpu_pc = 32'h404;
        settle();
        chk("t1_rdata", rdata, 32'h12345678);
        advance();

`ifndef DM_ARB_RR_EN
        // both held: four CPU grants, then one forced DMA grant
        cpu_req = 1'b1; dma_req = 1'b1; dma_addr = 32'h80;
        pat_c = '0; pat_d = '0; pat_s = '0;
        for (int i = 0; i < 10; i++) begin
            settle();
            pat_c[i] = cpu_gnt; pat_d[i] = dma_gnt; pat_s[i] = cpu_stall;
            advance();
        end
        chk("t2_cpu_pat", {20'h0, pat_c}, 32'h1EF);
        chk("t2_dma_pat", {20'h0, pat_d}, 32'h210);
        chk("t2_stall_pat", {20'h0, pat_s}, 32'h210);

        // locked burst opened from IDLE, CPU waiting: 8 DMA grants then CPU
        pat_c = '0; pat_d = '0; pat_s = '0;
        for (int i = 0; i < 12; i++) begin
            cpu_req = (i != 0); dma_req = 1'b1; dma_lock = 1'b1;
            settle();
            pat_c[i] = cpu_gnt; pat_d[i] = dma_gnt; pat_s[i] = cpu_stall;
            advance();
        end
        chk("t3_cpu_pat", {20'h0, pat_c}, 32'hF00);
        chk("t3_dma_pat", {20'h0, pat_d}, 32'h0FF);
        chk("t3_stall_pat", {20'h0, pat_s}, 32'h0FE);
`else
        // round-robin: simultaneous requests alternate starting with the CPU
        reset = 1'b1; settle(); advance(); reset = 1'b0;
        cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b0;
        pat_c = '0;
        for (int i = 0; i < 4; i++) begin
            settle();
            pat_c[i] = cpu_gnt;
            advance();
        end
        chk("t5_rr_pat", {28'h0, pat_c[3:0]}, 32'h5);
`endif

        // reset in the third cycle of a locked burst
        idle_inputs();
        reset = 1'b1; settle(); advance();
        reset = 1'b0; dma_req = 1'b1; dma_lock = 1'b1;
        settle(); chk("t4_open", dma_gnt, 1); advance();
        cpu_req = 1'b1;
        settle(); chk("t4_burst", dma_gnt, 1); advance();
        reset = 1'b1;
        settle();
        chk("t4_rst_cpu", cpu_gnt, 0);
        chk("t4_rst_dma", dma_gnt, 0);
        chk("t4_rst_we", dm_we, 0);
        chk("t4_rst_stall", cpu_stall, 0);
        advance();
        reset = 1'b0;
        settle();
        chk("t4_cpu_after", cpu_gnt, 1);
        advance();

        // DMA byte store then sign-extended byte load
        idle_inputs();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h23; dma_wd = 32'hAB; dma_width = 2'd2;
        settle();
        chk("t6_gnt", dma_gnt, 1);
        chk("t6_width", dm_width, 2);
        chk("t6_pc", dm_pc, 0);
        advance();
        dma_we = 1'b0; dma_sign = 1'b1;
        settle();
        chk("t6_rdata", rdata, 32'hFFFFFFAB);
        advance();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            cpu_req   = ($urandom_range(0, 9) < 6);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = $urandom;
            cpu_wd    = $urandom;
            cpu_width = 2'($urandom_range(0, 3));
            cpu_sign  = $urandom_range(0, 1) == 1;
            cpu_pc    = $urandom & 32'hFFFFFFFC;
            dma_req   = ($urandom_range(0, 9) < 5);
            dma_lock  = ($urandom_range(0, 9) < 7);
            dma_we    = $urandom_range(0, 1) == 1;
            dma_addr  = $urandom;
            dma_wd    = $urandom;
            dma_width = 2'($urandom_range(0, 3));
            dma_sign  = $urandom_range(0, 1) == 1;
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
